// File: rtl/debug_cmd_sequencer.sv
// Byte-stream command front end for debug_interface: decodes framed READ/WRITE
// commands, runs one debug transaction and returns a framed status/data response.
// Optional READ_NEXT opcode (0x03) is enabled by defining DBG_SEQ_AUTOINC_EN.
module debug_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        debug_enable,
  output logic [11:0] debug_addr,
  output logic        debug_read,
  output logic        debug_write,
  output logic [31:0] debug_write_data,
  input  logic [31:0] debug_read_data,
  input  logic        debug_ready,
  output logic        busy
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ADDR_HI    = 3'd1;
  localparam logic [2:0] S_ADDR_LO    = 3'd2;
  localparam logic [2:0] S_DATA       = 3'd3;
  localparam logic [2:0] S_ISSUE      = 3'd4;
  localparam logic [2:0] S_WAIT       = 3'd5;
  localparam logic [2:0] S_RSP_STATUS = 3'd6;
  localparam logic [2:0] S_RSP_DATA   = 3'd7;

  localparam logic [7:0] OP_READ       = 8'h01;
  localparam logic [7:0] OP_WRITE      = 8'h02;
`ifdef DBG_SEQ_AUTOINC_EN
  localparam logic [7:0] OP_READ_NEXT  = 8'h03;
`endif
  localparam logic [7:0] ST_OK         = 8'h00;
  localparam logic [7:0] ST_BAD_OPCODE = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT    = 8'hE2;
  localparam logic [7:0] WAIT_LAST     = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_reg, state_next;
  logic        is_write_reg;
  logic [1:0]  byte_cnt_reg;
  logic [7:0]  wait_cnt_reg;
  logic [7:0]  status_reg;
  logic [11:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [7:0]  rd_bytes [4];

  logic cmd_fire, rsp_fire, wait_done;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign wait_done = debug_ready || (wait_cnt_reg == WAIT_LAST);

  // Captured read data is returned MSB first: rd_bytes[0] goes out first.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd_bytes
      assign rd_bytes[gi] = rdata_reg[31 - 8*gi -: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_fire) begin
          if (cmd_data == OP_READ || cmd_data == OP_WRITE)
            state_next = S_ADDR_HI;
`ifdef DBG_SEQ_AUTOINC_EN
          else if (cmd_data == OP_READ_NEXT)
            state_next = S_ISSUE;
`endif
          else
            state_next = S_RSP_STATUS;
        end
      end
      S_ADDR_HI:    if (cmd_fire) state_next = S_ADDR_LO;
      S_ADDR_LO:    if (cmd_fire) state_next = is_write_reg ? S_DATA : S_ISSUE;
      S_DATA:       if (cmd_fire && byte_cnt_reg == 2'd3) state_next = S_ISSUE;
      S_ISSUE:      state_next = S_WAIT;
      S_WAIT:       if (wait_done) state_next = S_RSP_STATUS;
      S_RSP_STATUS: begin
        if (rsp_fire)
          state_next = (!is_write_reg && status_reg == ST_OK) ? S_RSP_DATA : S_IDLE;
      end
      S_RSP_DATA:   if (rsp_fire && byte_cnt_reg == 2'd3) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      is_write_reg <= 1'b0;
      byte_cnt_reg <= 2'd0;
      wait_cnt_reg <= 8'd0;
      status_reg   <= 8'd0;
      addr_reg     <= 12'd0;
      wdata_reg    <= 32'd0;
      rdata_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (cmd_fire) begin
            is_write_reg <= (cmd_data == OP_WRITE);
            // Overwritten in WAIT for legal opcodes; only reported for bad ones.
            status_reg   <= ST_BAD_OPCODE;
`ifdef DBG_SEQ_AUTOINC_EN
            // Low 11 bits wrap so the CSR-space select bit is preserved.
            if (cmd_data == OP_READ_NEXT)
              addr_reg <= {addr_reg[11], addr_reg[10:0] + 11'd1};
`endif
          end
        end
        S_ADDR_HI: if (cmd_fire) addr_reg[11:8] <= cmd_data[3:0];
        S_ADDR_LO: begin
          if (cmd_fire) begin
            addr_reg[7:0] <= cmd_data;
            byte_cnt_reg  <= 2'd0;
          end
        end
        S_DATA: begin
          if (cmd_fire) begin
            wdata_reg    <= {wdata_reg[23:0], cmd_data};
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
          end
        end
        S_ISSUE: begin
          wait_cnt_reg <= 8'd0;
          byte_cnt_reg <= 2'd0;
        end
        S_WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
          if (debug_ready) begin
            status_reg <= ST_OK;
            if (!is_write_reg) rdata_reg <= debug_read_data;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            status_reg <= ST_TIMEOUT;
          end
        end
        S_RSP_DATA: if (rsp_fire) byte_cnt_reg <= byte_cnt_reg + 2'd1;
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state_reg == S_IDLE) || (state_reg == S_ADDR_HI) ||
                     (state_reg == S_ADDR_LO) || (state_reg == S_DATA);
  assign rsp_valid = (state_reg == S_RSP_STATUS) || (state_reg == S_RSP_DATA);
  assign rsp_data  = (state_reg == S_RSP_STATUS) ? status_reg :
                     (state_reg == S_RSP_DATA)   ? rd_bytes[byte_cnt_reg] : 8'd0;
  assign busy      = (state_reg != S_IDLE);

  // Enable and strobes are gated by reset so they fall while reset is being sampled.
  assign debug_enable     = !reset && ((state_reg == S_ISSUE) || (state_reg == S_WAIT));
  assign debug_read       = !reset && (state_reg == S_ISSUE) && !is_write_reg;
  assign debug_write      = !reset && (state_reg == S_ISSUE) && is_write_reg;
  assign debug_addr       = addr_reg;
  assign debug_write_data = wdata_reg;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Directed self-checking bench for debug_cmd_sequencer with a simple
// debug_interface model that answers one cycle after each strobe.
module tb_debug_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_data = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic        debug_enable;
  logic [11:0] debug_addr;
  logic        debug_read;
  logic        debug_write;
  logic [31:0] debug_write_data;
  logic [31:0] debug_read_data = 32'd0;
  logic        debug_ready = 1'b0;
  logic        busy;

  logic        model_on = 1'b1;
  int          errors = 0;
  int          checks = 0;
  int          en_cnt, rd_cnt, wr_cnt;

  debug_cmd_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .debug_enable(debug_enable), .debug_addr(debug_addr),
    .debug_read(debug_read), .debug_write(debug_write),
    .debug_write_data(debug_write_data), .debug_read_data(debug_read_data),
    .debug_ready(debug_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // debug_interface model: completion one cycle after a strobe.
  always @(posedge clk) debug_ready <= model_on && (debug_read || debug_write);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  // Waits for rsp_valid, counting enable/strobe cycles along the way.
  task automatic wait_rsp();
    int n = 0;
    en_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    while (!rsp_valid && n < 100) begin
      en_cnt += int'(debug_enable);
      rd_cnt += int'(debug_read);
      wr_cnt += int'(debug_write);
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_arrives", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take_byte(input string tag, input logic [7:0] exp, input int stall);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_held"}, {24'd0, rsp_data}, {24'd0, exp});
      @(negedge clk);
    end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk(tag, {24'd0, rsp_data}, {24'd0, exp});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic seen_rsp;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_enable", {31'd0, debug_enable}, 32'd0);
    chk("rst_addr", {20'd0, debug_addr}, 32'd0);
    chk("rst_wdata", debug_write_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // READ 01 00 01 -> 00 00 00 00 01
    debug_read_data = 32'h0000_0001;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    chk("rd1_busy", {31'd0, busy}, 32'd1);
    wait_rsp();
    chk("rd1_addr", {20'd0, debug_addr}, 32'h001);
    chk("rd1_rd_strobes", rd_cnt, 1);
    chk("rd1_wr_strobes", wr_cnt, 0);
    chk("rd1_enable_cycles", en_cnt, 2);
    take_byte("rd1_status", 8'h00, 0);
    take_byte("rd1_b3", 8'h00, 0);
    take_byte("rd1_b2", 8'h00, 0);
    take_byte("rd1_b1", 8'h00, 0);
    take_byte("rd1_b0", 8'h01, 0);
    chk("rd1_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rd1_done_busy", {31'd0, busy}, 32'd0);

    // WRITE 02 00 02 12 34 56 78 -> 00
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    wait_rsp();
    chk("wr_wdata", debug_write_data, 32'h1234_5678);
    chk("wr_addr", {20'd0, debug_addr}, 32'h002);
    chk("wr_wr_strobes", wr_cnt, 1);
    chk("wr_rd_strobes", rd_cnt, 0);
    take_byte("wr_status", 8'h00, 0);
    chk("wr_done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wr_wdata_hold", debug_write_data, 32'h1234_5678);

    // CSR READ 01 08 01 with 5-cycle stalls on the response
    debug_read_data = 32'h0000_0801;
    send_byte(8'h01); send_byte(8'h08); send_byte(8'h01);
    wait_rsp();
    chk("csr_addr", {20'd0, debug_addr}, 32'h801);
    take_byte("csr_status", 8'h00, 5);
    take_byte("csr_b3", 8'h00, 0);
    take_byte("csr_b2", 8'h00, 5);
    take_byte("csr_b1", 8'h08, 5);
    take_byte("csr_b0", 8'h01, 0);
    chk("csr_done_valid", {31'd0, rsp_valid}, 32'd0);

    // Unknown opcode 7F -> E1, then 01 00 03 decodes normally
    send_byte(8'h7F);
    wait_rsp();
    chk("badop_no_strobe", en_cnt, 0);
    take_byte("badop_status", 8'hE1, 0);
    chk("badop_done_valid", {31'd0, rsp_valid}, 32'd0);
    debug_read_data = 32'hCAFE_0003;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
    wait_rsp();
    chk("after_bad_addr", {20'd0, debug_addr}, 32'h003);
    take_byte("after_bad_status", 8'h00, 0);
    take_byte("after_bad_b3", 8'hCA, 0);
    take_byte("after_bad_b2", 8'hFE, 0);
    take_byte("after_bad_b1", 8'h00, 0);
    take_byte("after_bad_b0", 8'h03, 0);

    // Opcode 03: READ_NEXT with wrap, or unknown opcode
    debug_read_data = 32'h1122_3344;
    send_byte(8'h01); send_byte(8'h07); send_byte(8'hFF);
    wait_rsp();
    chk("pre_next_addr", {20'd0, debug_addr}, 32'h7FF);
    repeat (5) take_byte("pre_next_drain", (rsp_data), 0);
`ifdef DBG_SEQ_AUTOINC_EN
    debug_read_data = 32'h5566_7788;
    send_byte(8'h03);
    wait_rsp();
    chk("next_addr_wrap", {20'd0, debug_addr}, 32'h000);
    chk("next_rd_strobes", rd_cnt, 1);
    take_byte("next_status", 8'h00, 0);
    take_byte("next_b3", 8'h55, 0);
    take_byte("next_b2", 8'h66, 0);
    take_byte("next_b1", 8'h77, 0);
    take_byte("next_b0", 8'h88, 0);
`else
    send_byte(8'h03);
    wait_rsp();
    chk("op03_no_strobe", en_cnt, 0);
    take_byte("op03_status", 8'hE1, 0);
    chk("op03_done_valid", {31'd0, rsp_valid}, 32'd0);
`endif

    // Timeout: debug_ready never asserted -> 17 enable cycles, then E2
    model_on = 1'b0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    wait_rsp();
    chk("to_enable_cycles", en_cnt, 17);
    chk("to_rd_strobes", rd_cnt, 1);
    take_byte("to_status", 8'hE2, 0);
    chk("to_done_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset during WAIT: no response, outputs back to reset values
    send_byte(8'h01); send_byte(8'h08); send_byte(8'h06);
    repeat (3) @(negedge clk);
    chk("mid_wait_enable", {31'd0, debug_enable}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst2_enable", {31'd0, debug_enable}, 32'd0);
    chk("rst2_read", {31'd0, debug_read}, 32'd0);
    chk("rst2_addr", {20'd0, debug_addr}, 32'd0);
    chk("rst2_wdata", debug_write_data, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    seen_rsp = 1'b0;
    repeat (30) begin
      seen_rsp |= rsp_valid;
      @(negedge clk);
    end
    chk("rst2_no_response", {31'd0, seen_rsp}, 32'd0);

`ifdef DBG_SEQ_AUTOINC_EN
    model_on = 1'b1;
    debug_read_data = 32'h0000_00AA;
    send_byte(8'h03);
    wait_rsp();
    chk("next_after_rst_addr", {20'd0, debug_addr}, 32'h001);
    take_byte("next_after_rst_status", 8'h00, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_cmd_sequencer.md
Name: debug_cmd_sequencer

Overview:
Byte-stream command front end that sits directly upstream of debug_interface. It takes framed debug commands from a host byte link, then drives debug_enable, debug_addr, debug_read, debug_write and debug_write_data. It waits for debug_ready, captures debug_read_data, and returns a framed status/data response as a byte stream. Single clock domain, one debug transaction outstanding at a time.

Parameters:
TIMEOUT_CYCLES, 16, number of WAIT cycles without debug_ready before the transaction is aborted (legal range 1..255).

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  host command byte valid
cmd_ready  output  1  sequencer accepts cmd_data this cycle
cmd_data  input  8  host command byte
rsp_valid  output  1  response byte valid
rsp_ready  input  1  host accepts rsp_data this cycle
rsp_data  output  8  response byte
debug_enable  output  1  to debug_interface; high during ISSUE and WAIT only
debug_addr  output  12  register/CSR address; bit 11 set selects CSR space
debug_read  output  1  one-cycle read strobe
debug_write  output  1  one-cycle write strobe
debug_write_data  output  32  write data
debug_read_data  input  32  read data from debug_interface
debug_ready  input  1  transaction complete from debug_interface
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset is synchronous and active-high; single clock clk. On reset: state=IDLE, and cmd_ready=1, rsp_valid=0, rsp_data=0, debug_enable=0, debug_read=0, debug_write=0, debug_addr=0, debug_write_data=0, busy=0.
- Frame format. Byte0 is the opcode: 0x01=READ, 0x02=WRITE. Byte1[3:0]=addr[11:8]; byte1[7:4] is ignored. Byte2=addr[7:0]. WRITE frames add 4 data bytes, MSB first.
- Byte transfer: a byte moves when valid&&ready on the same edge. cmd_ready=1 only in IDLE, ADDR_HI, ADDR_LO and DATA.
- States and transitions:
  - IDLE: accepts byte0. 0x01/0x02 go to ADDR_HI. Any other value latches status 0xE1 and goes to RSP_STATUS.
  - ADDR_HI -> ADDR_LO -> (READ: ISSUE | WRITE: DATA).
  - DATA: 2-bit counter collects 4 bytes into debug_write_data ({prev[23:0],byte}), then goes to ISSUE.
  - ISSUE: exactly one cycle. debug_enable=1, and debug_read or debug_write=1 per opcode. Next state is WAIT.
  - WAIT: debug_enable=1, strobes=0, wait counter increments each cycle. The first WAIT cycle with debug_ready=1 sets status 0x00, captures debug_read_data (READ only), and goes to RSP_STATUS. debug_ready during ISSUE is ignored. After TIMEOUT_CYCLES WAIT cycles with no debug_ready, status is 0xE2 and the state goes to RSP_STATUS.
  - RSP_STATUS: rsp_valid=1, rsp_data=status. On handshake: READ with status 0x00 goes to RSP_DATA; everything else goes to IDLE.
  - RSP_DATA: sends the 4 captured bytes MSB first, using a byte counter, then goes to IDLE.
- Response backpressure: rsp_valid and rsp_data stay stable until rsp_ready. rsp_ready held low stalls indefinitely; there is no timeout on the response side.
- debug_addr and debug_write_data hold their values after a transaction until the next frame overwrites them.
- Minimum latency: from the last command byte handshake to rsp_valid is 3 cycles (ISSUE, 1 WAIT cycle with debug_ready=1, then RSP_STATUS).
- A reset mid-frame or mid-WAIT discards the partial frame and any captured data. Strobes drop in the same cycle reset is sampled. No response is emitted.
- cmd_valid is ignored while cmd_ready=0; bytes offered then are not consumed.

Optional Feature:
DBG_SEQ_AUTOINC_EN
- Defined: opcode 0x03 = READ_NEXT. It carries no address bytes. The sequencer uses debug_addr+1, where the low 11 bits wrap (0x7FF->0x000, 0xFFF->0x800) so CSR/GPR space is preserved, then goes directly to ISSUE.
- READ_NEXT after reset uses address 0x001 (base 0x000).
- Not defined: 0x03 returns status 0xE1 like any unknown opcode.

Test Plan:
- READ frame 01 00 01; model returns 0x00000001 with debug_ready one cycle after the strobe -> debug_addr=0x001, one-cycle debug_read, response 00 00 00 00 01.
- WRITE frame 02 00 02 12 34 56 78 -> debug_write_data=0x12345678, debug_addr=0x002, one-cycle debug_write, response 00 only.
- READ of CSR 01 08 01; model returns 0x00000801 -> debug_addr=0x801, response 00 00 00 08 01. Repeat with rsp_ready low for 5 cycles: bytes held stable and none lost.
- Opcode 0x7F -> response E1 after 1 byte; the next frame 01 00 03 is decoded normally.
- READ with debug_ready never asserted -> debug_enable high for 1+16 cycles, then response E2; a reset during WAIT -> no response, all outputs return to reset values.
- With DBG_SEQ_AUTOINC_EN: 01 07 FF then 03 -> second access uses debug_addr=0x000. Without the macro, 03 -> E1.
